// File: rtl/i_ddr_align_ctrl.sv
// Word-alignment controller behind an I_DDR input register.
// Gathers 2-bit DDR samples into a history register. During training it
// bit-slips a word window until TRAIN_PATTERN is seen LOCK_COUNT times in a
// row. Once locked, it presents one aligned word per word period with a
// single-cycle WORD_VALID strobe.
module i_ddr_align_ctrl #(
    parameter int unsigned           WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int unsigned           LOCK_COUNT    = 4,
    parameter int unsigned           MAX_ATTEMPTS  = 16
) (
    input  logic                          C,
    input  logic                          R,
    input  logic                          START,
    input  logic [1:0]                    DDR_Q,
    output logic                          DDR_E,
    output logic [WORD_WIDTH-1:0]         WORD,
    output logic                          WORD_VALID,
    output logic                          LOCKED,
    output logic                          ERROR,
    output logic [$clog2(WORD_WIDTH)-1:0] SLIP
);

    localparam int unsigned HALF = WORD_WIDTH / 2;
    localparam int unsigned SW   = $clog2(WORD_WIDTH);
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(HALF - 1);
    localparam logic [SW-1:0] SLIP_LAST = SW'(WORD_WIDTH - 1);
    localparam logic [3:0]    LOCK_N    = 4'(LOCK_COUNT);
    localparam logic [7:0]    ATTEMPT_N = 8'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_CHECK,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t                  state;
    logic [BW-1:0]           beat;
    logic [2*WORD_WIDTH-1:0] hist;
    logic [3:0]              match_cnt;
    logic [7:0]              attempt_cnt;

    logic [WORD_WIDTH-1:0]   cand;
    logic                    boundary;
    logic                    is_match;
    logic [SW-1:0]           slip_inc;
    logic [3:0]              match_nxt;
    logic [7:0]              attempt_nxt;

    // Candidate word from the current window offset, plus next-value helpers.
    always_comb begin
        cand        = hist[SLIP +: WORD_WIDTH];
        boundary    = DDR_E && (beat == BEAT_LAST);
        is_match    = (cand == TRAIN_PATTERN);
        slip_inc    = (SLIP == SLIP_LAST) ? '0 : SLIP + 1'b1;
        match_nxt   = match_cnt + 4'd1;
        attempt_nxt = attempt_cnt + 8'd1;
    end

    // Capture, beat counting and training/lock state machine with registered outputs.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state       <= S_IDLE;
            DDR_E       <= 1'b0;
            WORD        <= '0;
            WORD_VALID  <= 1'b0;
            LOCKED      <= 1'b0;
            ERROR       <= 1'b0;
            SLIP        <= '0;
            beat        <= '0;
            hist        <= '0;
            match_cnt   <= '0;
            attempt_cnt <= '0;
        end else begin
            WORD_VALID <= 1'b0;

            if (DDR_E) begin
                hist <= {hist[2*WORD_WIDTH-3:0], DDR_Q[1], DDR_Q[0]};
                beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
            end

            if (START) begin
                // START overrides any boundary decision; hist keeps shifting.
                state       <= S_SEARCH;
                DDR_E       <= 1'b1;
                LOCKED      <= 1'b0;
                ERROR       <= 1'b0;
                SLIP        <= '0;
                beat        <= '0;
                match_cnt   <= '0;
                attempt_cnt <= '0;
            end else if (boundary) begin
                case (state)
                    S_SEARCH: begin
                        if (is_match) begin
                            match_cnt <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state  <= S_LOCKED;
                                LOCKED <= 1'b1;
                            end else begin
                                state <= S_CHECK;
                            end
                        end else begin
                            attempt_cnt <= attempt_nxt;
                            SLIP        <= slip_inc;
                            if (attempt_nxt >= ATTEMPT_N) begin
                                state <= S_FAIL;
                                ERROR <= 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (is_match) begin
                            match_cnt <= match_nxt;
                            if (match_nxt >= LOCK_N) begin
                                state  <= S_LOCKED;
                                LOCKED <= 1'b1;
                            end
                        end else begin
                            match_cnt   <= '0;
                            attempt_cnt <= attempt_nxt;
                            SLIP        <= slip_inc;
                            if (attempt_nxt >= ATTEMPT_N) begin
                                state <= S_FAIL;
                                ERROR <= 1'b1;
                            end else begin
                                state <= S_SEARCH;
                            end
                        end
                    end
                    S_LOCKED: begin
                        WORD       <= cand;
                        WORD_VALID <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i_ddr_align_ctrl.md
Name: i_ddr_align_ctrl

Overview:
- Word-alignment controller that sits directly after an I_DDR input register. It drives the I_DDR enable and gathers the 2-bit DDR samples into a history register.
- During training it searches for a known pattern by bit-slipping the word window. Once locked, it delivers aligned parallel words to fabric logic with a one-cycle valid strobe.
- One instance per DDR input lane. It runs in the same clock domain as the I_DDR clock C.

Parameters:
- WORD_WIDTH, 8, deserialized word width. Must be even and ≥4.
- TRAIN_PATTERN, 8'hA5, expected training word (WORD_WIDTH bits).
- LOCK_COUNT, 4, consecutive matching words required to declare lock (1..15).
- MAX_ATTEMPTS, 16, mismatched words tolerated before failure (1..255).

Ports:
- C  input  1  clock, shared with the I_DDR C.
- R  input  1  asynchronous active-low reset.
- START  input  1  single-cycle pulse that (re)starts training from any state.
- DDR_Q  input  2  I_DDR Q output. [1] is the rising-edge sample (earlier bit); [0] is the falling-edge sample.
- DDR_E  output  1  enable to the I_DDR E pin.
- WORD  output  WORD_WIDTH  aligned word.
- WORD_VALID  output  1  one-cycle strobe; WORD is valid while it is high.
- LOCKED  output  1  alignment achieved.
- ERROR  output  1  training failed.
- SLIP  output  clog2(WORD_WIDTH)  current bit offset.

Behaviour:
- Reset (R low, asynchronous):
  - state=IDLE.
  - DDR_E, WORD, WORD_VALID, LOCKED, ERROR, SLIP, beat counter, history, match and attempt counters all go to 0.
  - Release is synchronous to the next rising edge of C.
- DDR_E=1 in every state except IDLE.
- Capture and shifting:
  - Each rising edge with DDR_E=1: hist (2*WORD_WIDTH bits) <= {hist[2W-3:0], DDR_Q[1], DDR_Q[0]}.
  - beat counts 0..WORD_WIDTH/2-1 and wraps. A "boundary" is any cycle where beat==WORD_WIDTH/2-1.
- Candidate word: cand = hist[SLIP+WORD_WIDTH-1 : SLIP], combinational on the current hist.
- Evaluation happens at boundaries only. Any SLIP update takes effect at the next boundary.
- FSM:
  - IDLE: on START, go to SEARCH. Clear SLIP, beat, match_cnt and attempt_cnt.
  - SEARCH, at boundary:
    - cand==TRAIN_PATTERN: match_cnt=1, go to CHECK. If LOCK_COUNT==1, go straight to LOCKED instead.
    - Otherwise: attempt_cnt+1, SLIP+1 (wraps WORD_WIDTH-1 -> 0).
    - If attempt_cnt reaches MAX_ATTEMPTS: go to FAIL.
  - CHECK, at boundary:
    - Match: match_cnt+1. When match_cnt reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: match_cnt=0, attempt_cnt+1, SLIP+1, return to SEARCH. The FAIL rule also applies here.
  - LOCKED:
    - LOCKED=1.
    - At each boundary: WORD<=cand and WORD_VALID=1 on the following cycle for exactly one cycle.
    - The pattern is no longer checked. SLIP is frozen.
  - FAIL: ERROR=1, DDR_E stays 1, WORD_VALID=0. Stay here until START.
- WORD holds its last value between strobes and in all non-LOCKED states.
- START in any state (including LOCKED, FAIL, or mid-boundary) has priority over the boundary evaluation in the same cycle:
  - Go to SEARCH; clear LOCKED, ERROR, SLIP and all counters.
  - hist is not cleared.
- Latency from the pad: I_DDR register stage, then 1 hist stage, then the WORD register.

Test Plan:
- Reset behaviour: drive R low mid-LOCKED -> all outputs 0 immediately (no clock needed); after release, state IDLE and DDR_E=0.
- Aligned stream, W=8, pattern A5, LOCK_COUNT=4: START, then repeat A5 at offset 0 -> LOCKED after the 4th matching boundary with SLIP=0. Data word 3C then yields WORD=8'h3C and a single WORD_VALID pulse.
- Offset stream: A5 delayed by 3 bits -> SLIP increments 0,1,2,3 on mismatching boundaries. Lock reached with SLIP=3; LOCKED=1 after 3 mismatches plus 4 matches.
- Glitch during CHECK: 2 matches, then one corrupted word (A4) -> back to SEARCH, SLIP advances by 1, match_cnt resets. Relock only after 4 new consecutive matches.
- No pattern: constant 00 for 16 words -> ERROR=1, LOCKED=0, WORD_VALID never asserted. START then clears ERROR and training restarts.
- START coincident with a LOCKED boundary -> no WORD_VALID that cycle, LOCKED drops next edge, SLIP=0.
